gmii_mdio_ctrl: RTL

- Clause-22 MDIO management master that configures and reads the Ethernet PHYs on the repeater board.
- Replaces the tied-off MDC/MDIOO/MDIOE drive at the top level; one instance per PHY port.
- Accepts single read/write commands over a request/acknowledge handshake.
- Serialises each command into a 64-bit MDIO frame on a divided MDC clock and returns read data with a completion pulse.

---
 rtl/gmii_mdio_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gmii_mdio_ctrl.sv
// Clause-22 MDIO management master: serialises one read/write command into a
// 64-bit MDIO frame on a divided MDC clock and returns read data on completion.
module gmii_mdio_ctrl #(
  parameter int unsigned DIV = 25
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        CMD_REQ,
  input  logic        CMD_RD,
  input  logic [4:0]  CMD_PHYAD,
  input  logic [4:0]  CMD_REGAD,
  input  logic [15:0] CMD_WDAT,
  output logic        CMD_ACK,
  output logic        BUSY,
  output logic [15:0] RD_DAT,
  output logic        RD_VALID,
  output logic        RD_ERR,
  output logic        MDC,
  input  logic        MDIOI,
  output logic        MDIOO,
  output logic        MDIOE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      state;
  logic [63:0] frame_q;
  logic [5:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        rd_q;
  logic        gap_hi;
  logic        err_q;
  logic [15:0] shift_q;
  logic [63:0] new_frame;
  logic        div_end;

  // Preamble, ST, OP, PHYAD, REGAD, TA, DATA; a read never drives TA or DATA.
  assign new_frame = {32'hFFFF_FFFF, 2'b01, (CMD_RD ? 2'b10 : 2'b01),
                      CMD_PHYAD, CMD_REGAD, 2'b10, CMD_WDAT};
  assign div_end   = (div_cnt == DIV_LAST);

  // NOTE: every state register below uses <= so all updates on one edge see
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state    <= S_IDLE;
      frame_q  <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      rd_q     <= 1'b0;
      gap_hi   <= 1'b0;
      err_q    <= 1'b0;
      shift_q  <= '0;
      CMD_ACK  <= 1'b0;
      BUSY     <= 1'b0;
      RD_DAT   <= '0;
      RD_VALID <= 1'b0;
      RD_ERR   <= 1'b0;
      MDC      <= 1'b0;
      MDIOO    <= 1'b0;
      MDIOE    <= 1'b0;
    end else begin
      CMD_ACK  <= 1'b0;
      RD_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_REQ) begin
            state   <= S_FRAME;
            CMD_ACK <= 1'b1;
            BUSY    <= 1'b1;
            rd_q    <= CMD_RD;
            bit_cnt <= '0;
            div_cnt <= '0;
            err_q   <= 1'b0;
            shift_q <= '0;
            MDC     <= 1'b0;
            MDIOE   <= 1'b1;
            MDIOO   <= new_frame[63];
            frame_q <= {new_frame[62:0], 1'b0};
          end
        end

        S_FRAME: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!MDC) begin
              // Rising MDC: mid-bit, where the PHY's data is stable.
              MDC <= 1'b1;
              if (rd_q && bit_cnt >= 6'd47) begin
                if (bit_cnt == 6'd47) err_q <= MDIOI;
                else                  shift_q <= {shift_q[14:0], MDIOI};
              end
            end else begin
              MDC <= 1'b0;
              if (bit_cnt == 6'd63) begin
                state  <= S_DONE;
                gap_hi <= 1'b0;
                MDIOE  <= 1'b0;
                MDIOO  <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                frame_q <= {frame_q[62:0], 1'b0};
                // The PHY owns the pin from bit 46 of a read onwards.
                if (rd_q && bit_cnt >= 6'd45) begin
                  MDIOE <= 1'b0;
                  MDIOO <= 1'b0;
                end else begin
                  MDIOE <= 1'b1;
                  MDIOO <= frame_q[63];
                end
              end
            end
          end
        end

        S_DONE: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!gap_hi) begin
              gap_hi <= 1'b1;
            end else begin
              state  <= S_IDLE;
              BUSY   <= 1'b0;
              gap_hi <= 1'b0;
              if (rd_q) begin
                RD_DAT   <= shift_q;
                RD_ERR   <= err_q;
                RD_VALID <= 1'b1;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
